// File: rtl/tile_writeback_packer.sv
// ---------------------------------------------------------------------------
// tile_writeback_packer
//
// Writer side of the tiled 256-colour frame buffer. A raster-ordered pixel
// stream (one 8-bit colour per valid/ready handshake, row 0..15 then col
// 0..15 inside each 16x16 tile) is packed into a 2048-bit line. When the
// 256th pixel of a tile is taken, the tile position advances and a one-cycle
// write strobe is raised with the completed line. The frame buffer address of
// the tile just finished is therefore tile_y*TILES_X + tile_x - 1, wrapping to
// TILES_X*TILES_Y-1 on the final tile of a frame.
//
// Parameters
//   TILES_X           tiles per row (default 40, 640/16)
//   TILES_Y           tile rows     (default 30, 480/16)
//
// Ports
//   clk               sole clock
//   reset_n           asynchronous active-low reset
//   i_frame_start     1-cycle pulse, restart the frame at tile (0,0)
//   i_pixel_valid     pixel on i_pixel_color is valid
//   i_pixel_color     8-bit colour, raster order within the tile
//   o_pixel_ready     packer takes the pixel this cycle (valid & ready)
//   o_sm_render_done  1-cycle frame buffer write strobe
//   o_current_tile_x  tile being filled (already advanced during the strobe)
//   o_current_tile_y  tile row being filled (same timing as x)
//   o_sm_color_data   packed line, pixel (r,c) at bits 8*(16r+c) +: 8
//   o_frame_done      1-cycle pulse alongside the strobe of the last tile
// ---------------------------------------------------------------------------
module tile_writeback_packer #(
  parameter int TILES_X = 40,
  parameter int TILES_Y = 30
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_frame_start,
  input  logic          i_pixel_valid,
  input  logic [7:0]    i_pixel_color,
  output logic          o_pixel_ready,
  output logic          o_sm_render_done,
  output logic [5:0]    o_current_tile_x,
  output logic [5:0]    o_current_tile_y,
  output logic [2047:0] o_sm_color_data,
  output logic          o_frame_done
);

  localparam logic [5:0] LAST_X = 6'(TILES_X - 1);
  localparam logic [5:0] LAST_Y = 6'(TILES_Y - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      pix_cnt;
  logic [5:0]      tile_x;
  logic [5:0]      tile_y;
  logic [2047:0]   line;
  logic            accept;
  logic            last_pixel;
  logic            wrapped_to_origin;

  // A pixel is only consumed in FILL, and a simultaneous frame_start wins:
  // the offered pixel is dropped so the new frame starts clean at byte 0.
  assign accept     = (state == FILL) && i_pixel_valid && !i_frame_start;
  assign last_pixel = (pix_cnt == 8'd255);

  // FLUSH is only ever entered through a tile advance, so seeing (0,0) there
  // means the advance wrapped past the final tile of the frame.
  assign wrapped_to_origin = (tile_x == 6'd0) && (tile_y == 6'd0);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/strobe decode. The strobes are decoded straight
  // from the state so that an asynchronous reset removes them immediately.
  always_comb begin
    state_next       = state;
    o_pixel_ready    = 1'b0;
    o_sm_render_done = 1'b0;
    o_frame_done     = 1'b0;
    case (state)
      IDLE: begin
        if (i_frame_start) begin
          state_next = FILL;
        end
      end
      FILL: begin
        o_pixel_ready = 1'b1;
        if (accept && last_pixel) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        o_sm_render_done = 1'b1;
        o_frame_done     = wrapped_to_origin;
        if (i_frame_start) begin
          state_next = FILL;
        end else if (wrapped_to_origin) begin
          state_next = IDLE;
        end else begin
          state_next = FILL;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: pixel counter, tile position and the line being packed.
  // frame_start in any state rewinds the position; a partial line is simply
  // overwritten later because every byte is rewritten once per tile.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt <= 8'd0;
      tile_x  <= 6'd0;
      tile_y  <= 6'd0;
      line    <= '0;
    end else if (i_frame_start) begin
      pix_cnt <= 8'd0;
      tile_x  <= 6'd0;
      tile_y  <= 6'd0;
    end else if (accept) begin
      line[{pix_cnt, 3'b000} +: 8] <= i_pixel_color;
      pix_cnt                      <= pix_cnt + 8'd1;
      if (last_pixel) begin
        if (tile_x == LAST_X) begin
          tile_x <= 6'd0;
          if (tile_y == LAST_Y) begin
            tile_y <= 6'd0;
          end else begin
            tile_y <= tile_y + 6'd1;
          end
        end else begin
          tile_x <= tile_x + 6'd1;
        end
      end
    end
  end

  assign o_current_tile_x = tile_x;
  assign o_current_tile_y = tile_y;
  assign o_sm_color_data  = line;

endmodule

// File: tb/tb_tile_writeback_packer.sv
// ---------------------------------------------------------------------------
// tb_tile_writeback_packer
//
// Directed bench for tile_writeback_packer on a reduced 6x3 tile grid so a
// full frame stays short. The bench keeps its own tile position and line
// image and compares the write strobe, tile position, packed line and frame
// pulse against them.
// ---------------------------------------------------------------------------
module tb_tile_writeback_packer;

  localparam int TX = 6;
  localparam int TY = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_frame_start = 1'b0;
  logic          i_pixel_valid = 1'b0;
  logic [7:0]    i_pixel_color = 8'd0;
  logic          o_pixel_ready;
  logic          o_sm_render_done;
  logic [5:0]    o_current_tile_x;
  logic [5:0]    o_current_tile_y;
  logic [2047:0] o_sm_color_data;
  logic          o_frame_done;

  int checkCount = 0;
  int passCount = 0;
  int rdCount = 0;
  int fdCount = 0;
  int rdBase;
  int fdBase;
  bit stalled = 1'b0;

  logic [5:0]    expX = 6'd0;
  logic [5:0]    expY = 6'd0;
  logic [2047:0] expLine = '0;

  tile_writeback_packer #(
    .TILES_X(TX),
    .TILES_Y(TY)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_frame_start    (i_frame_start),
    .i_pixel_valid    (i_pixel_valid),
    .i_pixel_color    (i_pixel_color),
    .o_pixel_ready    (o_pixel_ready),
    .o_sm_render_done (o_sm_render_done),
    .o_current_tile_x (o_current_tile_x),
    .o_current_tile_y (o_current_tile_y),
    .o_sm_color_data  (o_sm_color_data),
    .o_frame_done     (o_frame_done)
  );

  always #5 clk = ~clk;

  // Strobes are counted mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (o_sm_render_done === 1'b1) rdCount++;
    if (o_frame_done === 1'b1) fdCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Index of the first differing byte, 256 when the lines agree.
  function automatic int firstDiff(input logic [2047:0] a, input logic [2047:0] b);
    for (int i = 0; i < 256; i++) begin
      if (a[8*i +: 8] !== b[8*i +: 8]) return i;
    end
    return 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frameStart();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    expX = 6'd0;
    expY = 6'd0;
  endtask

  // Offer one pixel and return just after the edge that takes it; valid is
  // left high so consecutive calls run back-to-back.
  task automatic sendPixel(input logic [7:0] c);
    int waited;
    waited = 0;
    if (stalled) return;
    i_pixel_valid = 1'b1;
    i_pixel_color = c;
    while (o_pixel_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (o_pixel_ready !== 1'b1) begin
      checkOutput("readyTimeout", {63'd0, o_pixel_ready}, 64'd1);
      stalled = 1'b1;
      return;
    end
    tick();
  endtask

  // Push one whole tile and check the strobe cycle that must follow it.
  task automatic applyStimulus(input bit gaps, input bit randomColors, input logic [7:0] base);
    logic [7:0] c;
    bit wasLast;
    for (int i = 0; i < 256; i++) begin
      if (stalled) return;
      c = randomColors ? 8'($urandom) : base + 8'(i);
      expLine[8*i +: 8] = c;
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_pixel_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      sendPixel(c);
    end
    if (stalled) return;
    wasLast = (expX == 6'(TX - 1)) && (expY == 6'(TY - 1));
    if (expX == 6'(TX - 1)) begin
      expX = 6'd0;
      expY = (expY == 6'(TY - 1)) ? 6'd0 : expY + 6'd1;
    end else begin
      expX = expX + 6'd1;
    end
    checkOutput("renderDone", {63'd0, o_sm_render_done}, 64'd1);
    checkOutput("readyInFlush", {63'd0, o_pixel_ready}, 64'd0);
    checkOutput("tileX", {58'd0, o_current_tile_x}, {58'd0, expX});
    checkOutput("tileY", {58'd0, o_current_tile_y}, {58'd0, expY});
    checkOutput("frameDone", {63'd0, o_frame_done}, {63'd0, wasLast});
    checkOutput("lineFirstBadByte", 64'(firstDiff(o_sm_color_data, expLine)), 64'd256);
  endtask

  initial begin
    // Reset values.
    repeat (3) tick();
    checkOutput("resetReady", {63'd0, o_pixel_ready}, 64'd0);
    checkOutput("resetRenderDone", {63'd0, o_sm_render_done}, 64'd0);
    checkOutput("resetFrameDone", {63'd0, o_frame_done}, 64'd0);
    checkOutput("resetTileX", {58'd0, o_current_tile_x}, 64'd0);
    checkOutput("resetTileY", {58'd0, o_current_tile_y}, 64'd0);
    checkOutput("resetData", 64'(firstDiff(o_sm_color_data, '0)), 64'd256);
    reset_n = 1'b1;
    tick();
    checkOutput("idleReady", {63'd0, o_pixel_ready}, 64'd0);

    // First tile back-to-back with colour = index, then a second tile whose
    // first pixel is already offered during the strobe cycle.
    $display("[TB] back-to-back tile and valid held through strobe");
    frameStart();
    checkOutput("fillReady", {63'd0, o_pixel_ready}, 64'd1);
    applyStimulus(1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'd0);
    i_pixel_valid = 1'b0;
    tick();
    checkOutput("afterFlushReady", {63'd0, o_pixel_ready}, 64'd1);
    checkOutput("afterFlushRenderDone", {63'd0, o_sm_render_done}, 64'd0);
    checkOutput("strobesTwoTiles", 64'(rdCount), 64'd2);

    // One row of tiles with random valid gaps.
    $display("[TB] row of tiles with gaps");
    frameStart();
    rdBase = rdCount;
    repeat (TX) applyStimulus(1'b1, 1'b1, 8'd0);
    i_pixel_valid = 1'b0;
    tick();
    checkOutput("rowStrobes", 64'(rdCount - rdBase), 64'(TX));
    checkOutput("rowTileX", {58'd0, o_current_tile_x}, 64'd0);
    checkOutput("rowTileY", {58'd0, o_current_tile_y}, 64'd1);

    // Whole frame, then IDLE ignores pixels.
    $display("[TB] full frame");
    frameStart();
    rdBase = rdCount;
    fdBase = fdCount;
    for (int t = 0; t < TX * TY; t++) applyStimulus(1'b0, 1'b0, 8'(t * 7));
    i_pixel_valid = 1'b0;
    tick();
    checkOutput("frameStrobes", 64'(rdCount - rdBase), 64'(TX * TY));
    checkOutput("framePulses", 64'(fdCount - fdBase), 64'd1);
    checkOutput("idleAfterFrameReady", {63'd0, o_pixel_ready}, 64'd0);
    i_pixel_valid = 1'b1;
    i_pixel_color = 8'h33;
    repeat (5) tick();
    checkOutput("idleIgnoresReady", {63'd0, o_pixel_ready}, 64'd0);
    checkOutput("idleIgnoresStrobes", 64'(rdCount - rdBase), 64'(TX * TY));
    i_pixel_valid = 1'b0;

    // Abort a partial tile at (5,2) with frame_start; the pixel offered in
    // the same cycle must be dropped.
    $display("[TB] frame_start mid-tile");
    frameStart();
    for (int t = 0; t < 2 * TX + 5; t++) applyStimulus(1'b0, 1'b0, 8'(t));
    for (int i = 0; i < 100; i++) sendPixel(8'hC0 + 8'(i));
    rdBase = rdCount;
    fdBase = fdCount;
    i_frame_start = 1'b1;
    i_pixel_valid = 1'b1;
    i_pixel_color = 8'hEE;
    tick();
    i_frame_start = 1'b0;
    i_pixel_valid = 1'b0;
    expX = 6'd0;
    expY = 6'd0;
    checkOutput("abortTileX", {58'd0, o_current_tile_x}, 64'd0);
    checkOutput("abortTileY", {58'd0, o_current_tile_y}, 64'd0);
    checkOutput("abortReady", {63'd0, o_pixel_ready}, 64'd1);
    checkOutput("abortNoStrobe", {63'd0, o_sm_render_done}, 64'd0);
    applyStimulus(1'b0, 1'b0, 8'h80);
    i_pixel_valid = 1'b0;
    tick();
    checkOutput("abortStrobes", 64'(rdCount - rdBase), 64'd1);
    checkOutput("abortFramePulses", 64'(fdCount - fdBase), 64'd0);

    // frame_start during the strobe, then asynchronous reset during a strobe.
    $display("[TB] frame_start and reset during strobe");
    frameStart();
    applyStimulus(1'b0, 1'b0, 8'h10);
    i_pixel_valid = 1'b0;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    expX = 6'd0;
    expY = 6'd0;
    checkOutput("flushStartTileX", {58'd0, o_current_tile_x}, 64'd0);
    checkOutput("flushStartReady", {63'd0, o_pixel_ready}, 64'd1);
    applyStimulus(1'b0, 1'b0, 8'h20);
    i_pixel_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncRenderDone", {63'd0, o_sm_render_done}, 64'd0);
    checkOutput("asyncReady", {63'd0, o_pixel_ready}, 64'd0);
    checkOutput("asyncTileX", {58'd0, o_current_tile_x}, 64'd0);
    checkOutput("asyncTileY", {58'd0, o_current_tile_y}, 64'd0);
    checkOutput("asyncFrameDone", {63'd0, o_frame_done}, 64'd0);
    checkOutput("asyncData", 64'(firstDiff(o_sm_color_data, '0)), 64'd256);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("postResetIdleReady", {63'd0, o_pixel_ready}, 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
